ledring_ctl: RTL
================

LEDRING_CTL -- requirements
Module: ledring_ctl

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 60, number of WS2812 pixels on the display-board ring (1..127).
REQ-002 SHALL have parameter CLK_HZ, default 50_000_000, clock frequency that the timing constants are derived for.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port address, input, 7, Avalon-MM word address.
REQ-006 SHALL have ports read and write, input, 1 each, Avalon-MM strobes.
REQ-007 SHALL have port writedata, input, 32, and port readdata, output, 32.
REQ-008 SHALL have port ring_out_n, output, 1, serial data to LEDRINGn (inverted by board hardware; ring-side high = 0 here).
REQ-009 SHALL have port busy, output, 1, high while a frame or latch gap is in progress.

Function
REQ-010 Addresses 0..NUM_LEDS-1 SHALL map to the pixel buffer, 24-bit {G[7:0],R[7:0],B[7:0]} in writedata[23:0]; writedata[31:24] is ignored.
REQ-011 Address 127 (CTRL) SHALL accept writes: bit0=1 requests a frame; other bits are ignored. Reads return {30'b0, pending, busy}.
REQ-012 Pixel reads SHALL return {8'b0, pixel}, with a fixed read latency of 1 cycle. Unmapped addresses SHALL read 0 and ignore writes.
REQ-013 The FSM SHALL have the states IDLE, LOAD, HIGH, LOW and LATCH.
REQ-014 IDLE: on a start request or pending=1, go to LOAD; pixel index=0 and bit index=23.
REQ-015 LOAD: fetch the pixel at the current index into a 24-bit shift register, then go to HIGH (1 cycle).
REQ-016 HIGH: ring_out_n=0 for T1H=40 cycles if the current bit is 1, or T0H=20 cycles if it is 0, then go to LOW.
REQ-017 LOW: ring_out_n=1 for TBIT-THx cycles (TBIT=62), so every bit lasts exactly 62 cycles.
REQ-018 At the end of LOW: if bit index>0, decrement it, shift, and go to HIGH. Else if pixel index<NUM_LEDS-1, increment it and go to LOAD. Else go to LATCH.
REQ-019 LOAD SHALL be absorbed into the preceding LOW's last cycle, so that inter-pixel bits are also exactly 62 cycles. The fetch is pipelined one cycle ahead.
REQ-020 LATCH: ring_out_n=1 for TRESET=15000 cycles (300 us), then go to IDLE.
REQ-021 Bits SHALL be sent MSB first (G7 first, B0 last).
REQ-022 Timing: a CTRL start write in cycle N gives ring_out_n falling at N+2. The frame lasts NUM_LEDS*24*62 cycles, followed by the latch gap.
REQ-023 busy SHALL be 0 only in IDLE.
REQ-024 A start write while busy SHALL set pending, a one-deep flag; further starts do not queue.
REQ-025 pending SHALL be cleared on entering LOAD from IDLE.
REQ-026 A start write in the same cycle that LATCH completes SHALL start the next frame without loss (pending semantics).
REQ-027 Pixel writes during a frame SHALL be accepted immediately. Pixels not yet loaded show the new value; a pixel already loaded is unaffected until the next frame.
REQ-028 A simultaneous pixel write and LOAD fetch of the same address SHALL fetch the old value.
REQ-029 Timing counters SHALL be 14-bit, saturating-free, reloaded on every state entry. Constants SHALL be computed from CLK_HZ at elaboration.

Reset
REQ-030 On reset: state=IDLE, ring_out_n=1, busy=0, pending=0, readdata=0, all counters=0.
REQ-031 Reset mid-frame SHALL abort the frame within 1 cycle. No latch gap is generated.
REQ-032 The pixel buffer SHALL NOT be reset; its contents after power-up are undefined.

Structure
REQ-033 Package ledring_pkg SHALL hold the state enum and the T0H/T1H/TBIT/TRESET constant functions of CLK_HZ.
REQ-034 Sub-module ledring_pixbuf SHALL implement the pixel buffer. It is a simple dual-port RAM (Avalon write port, FSM read port plus Avalon read port, registered outputs), M10K-inferable.

Verification
REQ-035 Reset, then write 0x00FF0000 to pixel 0 and start with NUM_LEDS=2. The first 8 bits SHALL be 40-cycle lows, all other bits 20-cycle lows, each bit 62 cycles; busy SHALL fall 2*24*62+15000+2 cycles after start.
REQ-036 Start during a frame -> CTRL reads 0b11. After the latch, a second frame SHALL begin with no intervening IDLE dwell beyond 1 cycle, and pending SHALL read 0.
REQ-037 Write pixel 1 = 0xFFFFFF while pixel 0 is being shifted -> pixel 1 SHALL be transmitted as all 40-cycle lows.
REQ-038 Assert reset in the middle of pixel 0 -> ring_out_n=1 and busy=0 on the next cycle; a new start SHALL produce a complete frame.
REQ-039 Write address 100 and read it -> readdata=0. Read pixel 1 after writing 0xAB123456 -> 0x00123456 one cycle after read.

Source files
------------

// File: rtl/ledring_pkg.sv
// Shared types and timing helpers for the WS2812 LED ring controller.
package ledring_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HIGH,
        ST_LOW,
        ST_LATCH
    } state_e;

    localparam int         CNT_W     = 14;
    localparam logic [6:0] CTRL_ADDR = 7'd127;

    // WS2812 timing in clock cycles, derived from the clock frequency in MHz.
    // 0.4 us
    function automatic int t0h_cyc(input int clk_hz);
        return (clk_hz / 1_000_000) * 4 / 10;
    endfunction

    // 0.8 us
    function automatic int t1h_cyc(input int clk_hz);
        return (clk_hz / 1_000_000) * 8 / 10;
    endfunction

    // 1.24 us full bit period
    function automatic int tbit_cyc(input int clk_hz);
        return (clk_hz / 1_000_000) * 124 / 100;
    endfunction

    // 300 us latch/reset gap
    function automatic int treset_cyc(input int clk_hz);
        return (clk_hz / 1_000_000) * 300;
    endfunction

endpackage

// File: rtl/ledring_pixbuf.sv
// Pixel buffer: one write port, two registered read ports (serializer fetch
// and bus read). Not reset, so it maps onto block RAM.
module ledring_pixbuf #(
    parameter int AW = 6,
    parameter int DW = 24
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          fre,
    input  logic [AW-1:0] faddr,
    output logic [DW-1:0] fdata,
    input  logic          are,
    input  logic [AW-1:0] aaddr,
    output logic [DW-1:0] adata
);

    logic [DW-1:0] mem_q [2**AW];

    // Write plus read-before-write registered reads (same-address read sees old data).
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (fre) begin
            fdata <= mem_q[faddr];
        end
        if (are) begin
            adata <= mem_q[aaddr];
        end
    end

endmodule

// File: rtl/ledring_ctl.sv
// WS2812 ring controller: Avalon-MM pixel buffer plus CTRL register, and a
// bit-serial frame engine driving the (board-inverted) ring data line.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for a start request or a pending start
// ST_LOAD  | first pixel of the frame lands in the shift register
// ST_HIGH  | ring line high (ring_out_n=0) for T0H/T1H of the current bit
// ST_LOW   | ring line low for the rest of the 62-cycle bit; later pixels
//          | are loaded on its last cycle (fetch issued one cycle earlier)
// ST_LATCH | ring line low for the latch gap
module ledring_ctl
    import ledring_pkg::*;
#(
    parameter int NUM_LEDS = 60,
    parameter int CLK_HZ   = 50_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        ring_out_n,
    output logic        busy
);

    localparam int PAW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [6:0] NPIX     = 7'(NUM_LEDS);
    localparam logic [6:0] LAST_PIX = 7'(NUM_LEDS - 1);

    localparam logic [CNT_W-1:0] H0  = CNT_W'(t0h_cyc(CLK_HZ) - 1);
    localparam logic [CNT_W-1:0] H1  = CNT_W'(t1h_cyc(CLK_HZ) - 1);
    localparam logic [CNT_W-1:0] L0  = CNT_W'(tbit_cyc(CLK_HZ) - t0h_cyc(CLK_HZ) - 1);
    localparam logic [CNT_W-1:0] L1  = CNT_W'(tbit_cyc(CLK_HZ) - t1h_cyc(CLK_HZ) - 1);
    localparam logic [CNT_W-1:0] LAT = CNT_W'(treset_cyc(CLK_HZ) - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [4:0]         bit_q, bit_d;
    logic [6:0]         pix_q, pix_d;
    logic [23:0]        shift_q, shift_d;
    logic               pending_q, pending_d;
    logic               ring_q, ring_d;
    logic               busy_q, busy_d;
    logic               sel_pix_q;
    logic [1:0]         ctrl_rd_q;

    logic               pix_hit, start;
    logic [6:0]         pix_nxt;
    logic               fre;
    logic [PAW-1:0]     faddr;
    logic [23:0]        fdata, adata;
    logic               unused_wd;

    assign pix_hit   = (address < NPIX);
    assign start     = write && (address == CTRL_ADDR) && writedata[0];
    assign pix_nxt   = pix_q + 7'd1;
    assign unused_wd = ^writedata[31:24];

    ledring_pixbuf #(.AW(PAW), .DW(24)) u_pixbuf (
        .clk   (clk),
        .we    (write && pix_hit),
        .waddr (address[PAW-1:0]),
        .wdata (writedata[23:0]),
        .fre   (fre),
        .faddr (faddr),
        .fdata (fdata),
        .are   (read && pix_hit),
        .aaddr (address[PAW-1:0]),
        .adata (adata)
    );

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            pix_q     <= '0;
            shift_q   <= '0;
            pending_q <= 1'b0;
            ring_q    <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            pix_q     <= pix_d;
            shift_q   <= shift_d;
            pending_q <= pending_d;
            ring_q    <= ring_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state: every state entry reloads the down-counter with duration-1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        pix_d   = pix_q;
        shift_d = shift_q;
        case (state_q)
            ST_IDLE: begin
                if (start || pending_q) begin
                    state_d = ST_LOAD;
                    pix_d   = '0;
                    bit_d   = 5'd23;
                end
            end
            ST_LOAD: begin
                state_d = ST_HIGH;
                shift_d = fdata;
                cnt_d   = fdata[23] ? H1 : H0;
            end
            ST_HIGH: begin
                if (cnt_q == '0) begin
                    state_d = ST_LOW;
                    cnt_d   = shift_q[23] ? L1 : L0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_LOW: begin
                if (cnt_q == '0) begin
                    if (bit_q != 5'd0) begin
                        state_d = ST_HIGH;
                        bit_d   = bit_q - 5'd1;
                        shift_d = {shift_q[22:0], 1'b0};
                        cnt_d   = shift_q[22] ? H1 : H0;
                    end else if (pix_q < LAST_PIX) begin
                        state_d = ST_HIGH;
                        pix_d   = pix_nxt;
                        bit_d   = 5'd23;
                        shift_d = fdata;
                        cnt_d   = fdata[23] ? H1 : H0;
                    end else begin
                        state_d = ST_LATCH;
                        cnt_d   = LAT;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_LATCH: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // One-deep start flag; consumed when a frame actually begins.
        pending_d = pending_q;
        if (state_q == ST_IDLE && state_d == ST_LOAD) begin
            pending_d = 1'b0;
        end else if (start && state_q != ST_IDLE) begin
            pending_d = 1'b1;
        end
    end

    // Outputs and pixel fetch, issued one cycle before the shift register loads.
    always_comb begin
        ring_d = (state_d != ST_HIGH);
        busy_d = (state_d != ST_IDLE);
        fre    = 1'b0;
        faddr  = '0;
        if (state_q == ST_IDLE && state_d == ST_LOAD) begin
            fre = 1'b1;
        end else if (state_q == ST_LOW && cnt_q == CNT_W'(1) && bit_q == 5'd0
                     && pix_q < LAST_PIX) begin
            fre   = 1'b1;
            faddr = pix_nxt[PAW-1:0];
        end
    end

    // Bus read path: one-cycle latency, unmapped addresses read zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_pix_q <= 1'b0;
            ctrl_rd_q <= 2'b00;
        end else begin
            sel_pix_q <= read && pix_hit;
            ctrl_rd_q <= (read && address == CTRL_ADDR) ? {pending_q, busy_q} : 2'b00;
        end
    end

    assign readdata   = sel_pix_q ? {8'b0, adata} : {30'b0, ctrl_rd_q};
    assign ring_out_n = ring_q;
    assign busy       = busy_q;

endmodule
